vram_writer: RTL and testbench

Frame-buffer writer for the VGA display path. It accepts single-pixel and filled-rectangle draw commands through a valid/ready handshake. It then emits one 12-bit RGB write per clock into the write port of the dual-port frame-buffer RAM, whose read port is scanned by the display pipeline. The frame buffer is 200×150 pixels, row-major, with address = y·H_RES + x, 15-bit address and 12-bit data.

---
 rtl/vram_writer.sv | 182 ++++++++++++++++++
 tb/tb_vram_writer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_writer.sv
// vram_writer: turns single-pixel and filled-rectangle draw commands into a
// stream of one-per-clock writes into the frame-buffer RAM write port.
// Addresses are row-major (y*H_RES + x). A row base register is stepped by
// H_RES at each row wrap, so the only multiply is the initial y0*H_RES.
module vram_writer #(
  parameter int H_RES  = 200,
  parameter int V_RES  = 150,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [7:0]        cmd_x0,
  input  logic [7:0]        cmd_x1,
  input  logic [7:0]        cmd_y0,
  input  logic [7:0]        cmd_y1,
  input  logic [DATA_W-1:0] cmd_color,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FILL,
    DONE,
    REJECT
  } state_t;

  // Coordinates are 8-bit; limits are compared unsigned at that width.
  localparam logic [7:0]        X_LIM    = 8'(H_RES);
  localparam logic [7:0]        Y_LIM    = 8'(V_RES);
  localparam logic [7:0]        X_MAX    = 8'(H_RES - 1);
  localparam logic [7:0]        Y_MAX    = 8'(V_RES - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

  state_t              state_q, state_d;
  logic                op_q, op_d;
  logic [7:0]          x0_q, x0_d;
  logic [7:0]          y0_q, y0_d;
  logic [7:0]          x1_q, x1_d;
  logic [7:0]          y1_q, y1_d;
  logic [7:0]          x_q, x_d;
  logic [7:0]          y_q, y_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Next-state and next-output logic for the IDLE/CHECK/FILL/DONE/REJECT sequence.
  always_comb begin
    // NOTE: every _d starts from a default so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // cmd_ready is high whenever IDLE is reached out of reset.
        if (cmd_valid) begin
          op_d    = cmd_op;
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          x1_d    = cmd_x1;
          y1_d    = cmd_y1;
          wdata_d = cmd_color;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (x0_q >= X_LIM || y0_q >= Y_LIM ||
            (op_q && (x0_q > x1_q || y0_q > y1_q))) begin
          err_d   = 1'b1;
          state_d = REJECT;
        end else begin
          if (!op_q) begin
            x1_d = x0_q;
            y1_d = y0_q;
          end else begin
            x1_d = (x1_q > X_MAX) ? X_MAX : x1_q;
            y1_d = (y1_q > Y_MAX) ? Y_MAX : y1_q;
          end
          x_d        = x0_q;
          y_d        = y0_q;
          row_base_d = ADDR_W'(y0_q) * ROW_STEP;
          waddr_d    = row_base_d + ADDR_W'(x0_q);
          we_d       = 1'b1;
          state_d    = FILL;
        end
      end

      FILL: begin
        // The write at (x_q, y_q) is on the port now; stage the next one.
        if (x_q != x1_q) begin
          x_d     = x_q + 8'd1;
          waddr_d = row_base_q + ADDR_W'(x_d);
          we_d    = 1'b1;
        end else if (y_q != y1_q) begin
          x_d        = x0_q;
          y_d        = y_q + 8'd1;
          row_base_d = row_base_q + ROW_STEP;
          waddr_d    = row_base_d + ADDR_W'(x0_q);
          we_d       = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE:    state_d = IDLE;
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset aborts any fill at once.
  always_ff @(posedge pclk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign we        = we_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vram_writer.sv
// Scoreboard bench for vram_writer: stimulus pushes expected writes/pulses
// (with their cycle stamps) into a queue; a negedge monitor pops and compares.
module tb_vram_writer;

  localparam int H    = 200;
  localparam int V    = 150;
  localparam int NPIX = H * V;

  logic        pclk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [7:0]  cmd_x0, cmd_x1, cmd_y0, cmd_y1;
  logic [11:0] cmd_color;
  logic [14:0] waddr;
  logic [11:0] wdata;
  logic        we, busy, done, err;

  vram_writer #(.H_RES(H), .V_RES(V), .ADDR_W(15), .DATA_W(12)) dut (
    .pclk(pclk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color),
    .waddr(waddr), .wdata(wdata), .we(we),
    .busy(busy), .done(done), .err(err)
  );

  always #5 pclk = ~pclk;

  typedef enum logic [1:0] {EV_WR, EV_DONE, EV_ERR} ev_e;
  typedef struct {
    ev_e    kind;
    int     addr;
    int     data;
    longint cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  longint      ecnt    = 0;
  int          wr_cnt  = 0;
  logic [11:0] mem [NPIX];

  // Edge counter: after accept edge A, spec cycle c is observed at ecnt == A + c - 1.
  always @(posedge pclk) ecnt <= ecnt + 1;

  // Behavioural frame-buffer RAM behind the write port.
  always @(posedge pclk) begin
    if (we) begin
      wr_cnt <= wr_cnt + 1;
      if (int'(waddr) < NPIX) mem[waddr] <= wdata;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (ecnt %0d)", name, act, exp, ecnt);
    end
  endtask

  function automatic logic [2:0] kbits(input ev_e k);
    case (k)
      EV_WR:   return 3'b100;
      EV_DONE: return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // Monitor: compare every presented write / done / err against the queue head.
  logic [2:0] mon_ev;
  exp_t       mon_e;
  always @(negedge pclk) begin
    mon_ev = {we, done, err};
    if (mon_ev == 3'b100 || mon_ev == 3'b010 || mon_ev == 3'b001 || (mon_ev != 3'b000 && mon_ev != 3'bxxx && ^mon_ev !== 1'bx)) begin
      if (sb.size() == 0) begin
        check("output_without_expectation", {61'd0, mon_ev}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("event_kind", {61'd0, mon_ev}, {61'd0, kbits(mon_e.kind)});
        check("event_cycle", ecnt, mon_e.cyc);
        if (mon_e.kind == EV_WR) begin
          check("waddr", {49'd0, waddr}, mon_e.addr);
          check("wdata", {52'd0, wdata}, mon_e.data);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc <= ecnt) begin
      mon_e = sb.pop_front();
      check("missing_event", {61'd0, mon_ev}, {61'd0, kbits(mon_e.kind)});
    end
  end

  task automatic push_wr(input int addr, input int data, input longint cyc);
    exp_t e;
    e.kind = EV_WR; e.addr = addr; e.data = data; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic push_ev(input ev_e kind, input longint cyc);
    exp_t e;
    e.kind = kind; e.addr = 0; e.data = 0; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Reference model of a clamped rectangle fill starting at accept edge a.
  task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                           input int color, input longint a);
    longint c = a + 1;
    int xe = (x1 > H - 1) ? H - 1 : x1;
    int ye = (y1 > V - 1) ? V - 1 : y1;
    for (int y = y0; y <= ye; y++)
      for (int x = x0; x <= xe; x++) begin
        push_wr(y * H + x, color, c);
        c++;
      end
    push_ev(EV_DONE, c);
  endtask

  // Present a command (called at a negedge); returns the ecnt value after the accept edge.
  task automatic send(input bit op, input int x0, input int y0, input int x1, input int y1,
                      input int color, output longint a);
    int budget = 0;
    cmd_op = op;
    cmd_x0 = 8'(x0); cmd_y0 = 8'(y0); cmd_x1 = 8'(x1); cmd_y1 = 8'(y1);
    cmd_color = 12'(color);
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && budget < 40000) begin
      @(negedge pclk);
      budget++;
    end
    if (cmd_ready !== 1'b1) check("accept_timeout", {63'd0, cmd_ready}, 64'd1);
    a = ecnt + 1;
  endtask

  // Step past the accept edge and scramble the command fields, which must be ignored.
  task automatic release_cmd(input bit hold);
    @(negedge pclk);
    if (!hold) cmd_valid = 1'b0;
    cmd_x0 = 8'hA5; cmd_y0 = 8'h5A; cmd_x1 = 8'h00; cmd_y1 = 8'h00;
    cmd_color = 12'h555; cmd_op = ~cmd_op;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(sb.size() == 0 && cmd_ready === 1'b1) && n < budget) begin
      @(negedge pclk);
      n++;
    end
    if (sb.size() != 0) check("idle_timeout", sb.size(), 64'd0);
  endtask

  longint a, a2;
  int     wr0, bad;

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 12'h000;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;
    repeat (3) @(negedge pclk);

    check("rst_we",    {63'd0, we},   64'd0);
    check("rst_waddr", {49'd0, waddr}, 64'd0);
    check("rst_wdata", {52'd0, wdata}, 64'd0);
    check("rst_done",  {63'd0, done}, 64'd0);
    check("rst_err",   {63'd0, err},  64'd0);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, cmd_ready}, 64'd0);
    rst = 1'b0;
    @(negedge pclk);
    check("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    // Pixel (10,5) then, with cmd_valid held, pixel (199,149).
    send(1'b0, 10, 5, 0, 0, 'hF00, a);
    push_wr(1010, 'hF00, a + 1);
    push_ev(EV_DONE, a + 2);
    release_cmd(1'b1);
    send(1'b0, 199, 149, 0, 0, 'h123, a2);
    check("pixel_spacing", a2 - a, 64'd4);
    push_wr(29999, 'h123, a2 + 1);
    push_ev(EV_DONE, a2 + 2);
    release_cmd(1'b0);
    wait_idle(50);

    // Rect (0,0)-(2,1) across a row wrap.
    send(1'b1, 0, 0, 2, 1, 'h0F0, a);
    push_wr(0,   'h0F0, a + 1);
    push_wr(1,   'h0F0, a + 2);
    push_wr(2,   'h0F0, a + 3);
    push_wr(200, 'h0F0, a + 4);
    push_wr(201, 'h0F0, a + 5);
    push_wr(202, 'h0F0, a + 6);
    push_ev(EV_DONE, a + 7);
    release_cmd(1'b0);
    check("busy_in_check", {63'd0, busy}, 64'd1);
    check("ready_low_busy", {63'd0, cmd_ready}, 64'd0);
    wait_idle(50);

    // Clamped rect (198,148)-(255,255).
    send(1'b1, 198, 148, 255, 255, 'h00F, a);
    push_wr(29798, 'h00F, a + 1);
    push_wr(29799, 'h00F, a + 2);
    push_wr(29998, 'h00F, a + 3);
    push_wr(29999, 'h00F, a + 4);
    push_ev(EV_DONE, a + 5);
    release_cmd(1'b0);
    wait_idle(50);

    // Rejected commands, back to back with cmd_valid held.
    send(1'b1, 5, 0, 3, 0, 'h111, a);
    push_ev(EV_ERR, a + 1);
    release_cmd(1'b1);
    send(1'b0, 200, 0, 0, 0, 'h222, a2);
    check("reject_spacing_1", a2 - a, 64'd3);
    push_ev(EV_ERR, a2 + 1);
    release_cmd(1'b1);
    a = a2;
    send(1'b1, 0, 7, 0, 6, 'h333, a2);
    check("reject_spacing_2", a2 - a, 64'd3);
    push_ev(EV_ERR, a2 + 1);
    release_cmd(1'b1);
    a = a2;
    send(1'b0, 0, 150, 0, 0, 'h444, a2);
    check("reject_spacing_3", a2 - a, 64'd3);
    push_ev(EV_ERR, a2 + 1);
    release_cmd(1'b1);
    a = a2;
    send(1'b1, 200, 0, 210, 0, 'h666, a2);
    check("reject_spacing_4", a2 - a, 64'd3);
    push_ev(EV_ERR, a2 + 1);
    release_cmd(1'b0);
    wait_idle(50);

    // 100-pixel fill (0,10)-(9,19), reset during write #50.
    send(1'b1, 0, 10, 9, 19, 'h3C3, a);
    for (int k = 1; k <= 50; k++)
      push_wr((10 + (k - 1) / 10) * H + (k - 1) % 10, 'h3C3, a + k);
    release_cmd(1'b0);
    while (ecnt < a + 50) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    check("abort_we",    {63'd0, we},   64'd0);
    check("abort_done",  {63'd0, done}, 64'd0);
    check("abort_busy",  {63'd0, busy}, 64'd0);
    check("abort_ready_in_rst", {63'd0, cmd_ready}, 64'd0);
    rst = 1'b0;
    @(negedge pclk);
    check("abort_ready_after", {63'd0, cmd_ready}, 64'd1);
    check("abort_kept_pixel", {52'd0, mem[14 * H + 9]}, 64'h3C3);
    check("abort_unwritten",  {52'd0, mem[15 * H + 0]}, 64'h000);
    send(1'b0, 3, 2, 0, 0, 'h0AA, a);
    push_wr(403, 'h0AA, a + 1);
    push_ev(EV_DONE, a + 2);
    release_cmd(1'b0);
    wait_idle(50);

    // Full-screen fill and readback.
    wr0 = wr_cnt;
    send(1'b1, 0, 0, 199, 149, 'hABC, a);
    push_rect(0, 0, 199, 149, 'hABC, a);
    release_cmd(1'b0);
    wait_idle(40000);
    @(negedge pclk);
    check("full_fill_writes", wr_cnt - wr0, NPIX);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (mem[i] !== 12'hABC) bad++;
    check("full_fill_readback_bad", bad, 64'd0);

    check("scoreboard_drained", sb.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
